aes_axis_collector: RTL and testbench



---
 rtl/aes_axis_collector.sv | 150 +++++++++++++++
 tb/tb_aes_axis_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_collector.sv
// AXI4-Stream packet collector for the AES controller: captures a command word
// plus payload, hands them to the controller and waits for its completion.
module aes_axis_collector #(
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned WORD_S     = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [WORD_S-1:0]            s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [WORD_S-1:0]            aes_cmd,
    output logic [FIFO_DEPTH*WORD_S-1:0] in_fifo,
    output logic [WORD_S-1:0]            in_fifo_last,
    output logic                         en_o,
    input  logic                         done_i,
    output logic                         err_o
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [1:0] ST_CMD  = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              tready_q, tready_d;
    logic [WORD_S-1:0] aes_cmd_q, aes_cmd_d;
    logic [WORD_S-1:0] last_q, last_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;
    logic              en_q, en_d;
    logic              err_q, err_d;

    logic              hs_c;
    logic              room_c;
    logic [PTR_W-1:0]  count_c;
    logic              reject_c;
    logic              wr_en_c;
    logic [IDX_W-1:0]  wr_idx_c;

    logic [WORD_S-1:0] mem_q [FIFO_DEPTH];

    always_comb begin
        state_d   = state_q;
        aes_cmd_d = aes_cmd_q;
        last_d    = last_q;
        wr_ptr_d  = wr_ptr_q;
        ovf_d     = ovf_q;
        en_d      = 1'b0;
        err_d     = 1'b0;
        wr_en_c   = 1'b0;
        wr_idx_c  = wr_ptr_q[IDX_W-1:0];

        hs_c     = s_axis_tvalid & tready_q;
        room_c   = (wr_ptr_q < PTR_W'(FIFO_DEPTH));
        // Count saturates at capacity; overflow on the tlast word still rejects.
        count_c  = room_c ? (wr_ptr_q + PTR_W'(1)) : PTR_W'(FIFO_DEPTH);
        reject_c = ovf_q | ~room_c | (count_c[1:0] != 2'b00);

        case (state_q)
            ST_CMD: begin
                if (hs_c) begin
                    aes_cmd_d = s_axis_tdata;
                    wr_ptr_d  = '0;
                    ovf_d     = 1'b0;
                    if (s_axis_tlast) begin
                        last_d  = '0;
                        en_d    = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (hs_c) begin
                    if (room_c) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (reject_c) begin
                            err_d   = 1'b1;
                            state_d = ST_CMD;
                        end else begin
                            last_d  = WORD_S'(count_c);
                            en_d    = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (done_i) begin
                    state_d = ST_CMD;
                end
            end
            default: begin
                state_d = ST_CMD;
            end
        endcase

        tready_d = (state_d != ST_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CMD;
            tready_q  <= 1'b0;
            aes_cmd_q <= '0;
            last_q    <= '0;
            wr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tready_q  <= tready_d;
            aes_cmd_q <= aes_cmd_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            err_q     <= err_d;
        end
    end

    // Payload storage carries no reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_idx_c] <= s_axis_tdata;
        end
    end

    for (genvar i = 0; i < int'(FIFO_DEPTH); i++) begin : g_flat
        assign in_fifo[i*WORD_S +: WORD_S] = mem_q[i];
    end

    assign s_axis_tready = tready_q;
    assign aes_cmd       = aes_cmd_q;
    assign in_fifo_last  = last_q;
    assign en_o          = en_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_aes_axis_collector.sv
// Directed bench for aes_axis_collector with a packet scoreboard and an
// 8-word payload store so overflow is reachable.
module tb_aes_axis_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = 32;

    logic               clk;
    logic               reset_n;
    logic [W-1:0]       s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tlast;
    logic               s_axis_tready;
    logic [W-1:0]       aes_cmd;
    logic [DEPTH*W-1:0] in_fifo;
    logic [W-1:0]       in_fifo_last;
    logic               en_o;
    logic               done_i;
    logic               err_o;

    aes_axis_collector #(.FIFO_DEPTH(DEPTH), .WORD_S(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .aes_cmd      (aes_cmd),
        .in_fifo      (in_fifo),
        .in_fifo_last (in_fifo_last),
        .en_o         (en_o),
        .done_i       (done_i),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [DEPTH*W-1:0] words;
        logic [W-1:0]       cmd;
        logic [W-1:0]       last;
        logic [7:0]         stored;
        logic               ok;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] pay [16];
    logic [W-1:0] model_last;
    int           total;
    int           bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic fill_pay();
        for (int i = 0; i < 16; i++) pay[i] = $urandom;
    endtask

    // Model the outcome, push it, then drive command plus n payload words.
    task automatic send_packet(input logic [W-1:0] cmd, input int n, input bit gaps);
        exp_t e;
        int   stored;
        int   cnt;
        stored   = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        e        = '0;
        e.cmd    = cmd;
        e.stored = 8'(stored);
        e.ok     = (n <= int'(DEPTH)) && ((stored % 4) == 0);
        for (int i = 0; i < stored; i++) e.words[i*W +: W] = pay[i];
        if (e.ok) model_last = W'(stored);
        e.last = model_last;
        sb.push_back(e);
        for (int i = 0; i <= n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = (i == 0) ? cmd : pay[i-1];
            s_axis_tlast  = (i == n);
            cnt = 0;
            while (!s_axis_tready) begin
                @(negedge clk);
                cnt++;
                if (cnt > 20) begin
                    chk("tready_timeout", 32'(s_axis_tready), 32'd1);
                    s_axis_tvalid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Called on the cycle after the tlast handshake.
    task automatic check_outcome(input bit check_next);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("en_o", 32'(en_o), 32'(e.ok));
        chk("err_o", 32'(err_o), 32'(!e.ok));
        chk("aes_cmd", aes_cmd, e.cmd);
        chk("in_fifo_last", in_fifo_last, e.last);
        for (int i = 0; i < int'(e.stored); i++)
            chk($sformatf("in_fifo[%0d]", i), in_fifo[i*W +: W], e.words[i*W +: W]);
        if (check_next) begin
            @(negedge clk);
            chk("en_o_pulse", 32'(en_o), 32'd0);
            chk("err_o_pulse", 32'(err_o), 32'd0);
            chk("tready_after", 32'(s_axis_tready), 32'(!e.ok));
        end
    endtask

    task automatic release_wait();
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        chk("tready_after_done", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        chk({tag, "_en"}, 32'(en_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_cmd"}, aes_cmd, 32'd0);
        chk({tag, "_last"}, in_fifo_last, 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_last = '0;
        reset_n = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        done_i = 1'b0;

        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("tready_idle", 32'(s_axis_tready), 32'd1);

        // Encrypt packet with one 128-bit block
        fill_pay();
        send_packet(32'h20, 4, 1'b0);
        check_outcome(1'b1);
        release_wait();

        // Set-key packet, then a second command held off until done
        fill_pay();
        send_packet(32'h10, 8, 1'b0);
        check_outcome(1'b1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h20;
        s_axis_tlast  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("tready_wait", 32'(s_axis_tready), 32'd0);
            chk("cmd_held", aes_cmd, 32'h10);
            chk("last_held", in_fifo_last, 32'd8);
        end
        release_wait();
        fill_pay();
        send_packet(32'h20, 4, 1'b0);
        check_outcome(1'b1);
        release_wait();

        // Partial block rejected, then a good packet
        fill_pay();
        send_packet(32'h20, 6, 1'b0);
        check_outcome(1'b1);
        fill_pay();
        send_packet(32'h20, 8, 1'b0);
        check_outcome(1'b1);
        release_wait();

        // Overflow: 12 words into 8 slots
        fill_pay();
        send_packet(32'h20, 12, 1'b0);
        check_outcome(1'b1);

        // Zero-length payload
        send_packet(32'h10, 0, 1'b0);
        check_outcome(1'b1);
        release_wait();

        // tvalid gaps inside a packet
        fill_pay();
        send_packet(32'h20, 8, 1'b1);
        check_outcome(1'b1);
        release_wait();

        // done_i in the same cycle as en_o
        fill_pay();
        send_packet(32'h10, 4, 1'b0);
        check_outcome(1'b0);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        chk("tready_done_same", 32'(s_axis_tready), 32'd1);
        chk("en_done_same", 32'(en_o), 32'd0);

        // Reset mid-DATA
        fill_pay();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h20;
        s_axis_tlast  = 1'b0;
        @(negedge clk);
        s_axis_tdata = pay[0];
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_data");
        model_last = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_data_en", 32'(en_o), 32'd0);
        chk("rst_data_tready", 32'(s_axis_tready), 32'd1);
        fill_pay();
        send_packet(32'h20, 4, 1'b0);
        check_outcome(1'b0);

        // Reset mid-WAIT (en_o is high at this point)
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_wait");
        model_last = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_wait_tready", 32'(s_axis_tready), 32'd1);
        fill_pay();
        send_packet(32'h20, 8, 1'b1);
        check_outcome(1'b1);
        release_wait();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
